// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/write-back bundle between register file and muldiv_unit
//   master (register-file side) drives : Start, Op, OperandA, OperandB, DestReg
//   slave  (muldiv_unit side)   drives : Busy, WriteData, RD, RegWrite, DivByZero
interface muldiv_unit_if #(
   parameter int WIDTH = 16,
   parameter int ADDR  = 3
) ();
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] OperandA;
   logic [WIDTH-1:0] OperandB;
   logic [ADDR-1:0]  DestReg;
   logic             Busy;
   logic [WIDTH-1:0] WriteData;
   logic [ADDR-1:0]  RD;
   logic             RegWrite;
   logic             DivByZero;

   modport master (
      output Start, Op, OperandA, OperandB, DestReg,
      input  Busy, WriteData, RD, RegWrite, DivByZero
   );

   modport slave (
      input  Start, Op, OperandA, OperandB, DestReg,
      output Busy, WriteData, RD, RegWrite, DivByZero
   );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle unsigned 16-bit multiply/divide with register-file write-back
//   Clock   : single clock, posedge
//   Reset_n : asynchronous active-low reset
//   bus     : muldiv_unit_if.slave (Start/Op/OperandA/OperandB/DestReg in,
//             Busy/WriteData/RD/RegWrite/DivByZero out)
//   MULDIV_DIV_EN : when defined, the divider datapath is compiled in; otherwise
//                   DIV/REM ops complete with WriteData=0 and DivByZero=0.
module muldiv_unit #(
   parameter int WIDTH = 16,
   parameter int ADDR  = 3
) (
   input  logic         Clock,
   input  logic         Reset_n,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [ADDR-1:0]  dest_q, dest_d;
   // opnd: fixed operand (multiplicand for MUL, divisor for DIV)
   logic [WIDTH-1:0] opnd_q, opnd_d;
   // sh: shifting register (multiplier -> product low half, dividend -> quotient)
   logic [WIDTH-1:0] sh_q, sh_d;
   // acc: product high half for MUL, partial remainder for DIV
   logic [WIDTH:0]   acc_q, acc_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             reg_write_q, reg_write_d;
   logic             div_by_zero_q, div_by_zero_d;
   logic [WIDTH-1:0] write_data_q, write_data_d;
   logic [ADDR-1:0]  rd_q, rd_d;

   logic [WIDTH:0]   mul_sum;
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      dest_d        = dest_q;
      opnd_d        = opnd_q;
      sh_d          = sh_q;
      acc_d         = acc_q;
      dz_d          = dz_q;
      busy_d        = busy_q;
      reg_write_d   = 1'b0;
      div_by_zero_d = 1'b0;
      write_data_d  = write_data_q;
      rd_d          = rd_q;
      mul_sum       = acc_q + (sh_q[0] ? {1'b0, opnd_q} : '0);
`ifdef MULDIV_DIV_EN
      div_shift     = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
      div_diff      = {1'b0, div_shift} - {2'b00, opnd_q};
`endif

      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               state_d = RUN;
               busy_d  = 1'b1;
               cnt_d   = CW'(WIDTH);
               op_d    = bus.Op;
               dest_d  = bus.DestReg;
               acc_d   = '0;
               if (!bus.Op[1]) begin
                  opnd_d = bus.OperandA;
                  sh_d   = bus.OperandB;
               end else begin
                  opnd_d = bus.OperandB;
                  sh_d   = bus.OperandA;
               end
`ifdef MULDIV_DIV_EN
               dz_d = bus.Op[1] && (bus.OperandB == '0);
`else
               dz_d = 1'b0;
`endif
            end
         end

         RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (!op_q[1]) begin
               // Shift-add: {acc, sh} shifts right one place per step.
               acc_d = {1'b0, mul_sum[WIDTH:1]};
               sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
            end else begin
`ifdef MULDIV_DIV_EN
               // Restoring division; a zero divisor naturally yields an
               // all-ones quotient and the dividend as remainder.
               if (!div_diff[WIDTH+1]) begin
                  acc_d = div_diff[WIDTH:0];
                  sh_d  = {sh_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = div_shift;
                  sh_d  = {sh_q[WIDTH-2:0], 1'b0};
               end
`endif
            end

            if (cnt_q == CW'(1)) begin
               state_d       = WRITE;
               reg_write_d   = 1'b1;
               rd_d          = dest_q;
               div_by_zero_d = dz_q;
               // Result taken from the final-iteration values.
               case (op_q)
                  2'b00:   write_data_d = sh_d;
                  2'b01:   write_data_d = acc_d[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
                  2'b10:   write_data_d = sh_d;
                  default: write_data_d = acc_d[WIDTH-1:0];
`else
                  default: write_data_d = '0;
`endif
               endcase
            end
         end

         WRITE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         op_q          <= '0;
         dest_q        <= '0;
         opnd_q        <= '0;
         sh_q          <= '0;
         acc_q         <= '0;
         dz_q          <= 1'b0;
         busy_q        <= 1'b0;
         reg_write_q   <= 1'b0;
         div_by_zero_q <= 1'b0;
         write_data_q  <= '0;
         rd_q          <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         dest_q        <= dest_d;
         opnd_q        <= opnd_d;
         sh_q          <= sh_d;
         acc_q         <= acc_d;
         dz_q          <= dz_d;
         busy_q        <= busy_d;
         reg_write_q   <= reg_write_d;
         div_by_zero_q <= div_by_zero_d;
         write_data_q  <= write_data_d;
         rd_q          <= rd_d;
      end
   end

   assign bus.Busy      = busy_q;
   assign bus.RegWrite  = reg_write_q;
   assign bus.DivByZero = div_by_zero_q;
   assign bus.WriteData = write_data_q;
   assign bus.RD        = rd_q;
endmodule
